// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port SRAM between a loader port (0) and a compute port (1).
module sram_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 11,
    parameter int CNT_BITS  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [WIDTH-1:0]     req0_wdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [WIDTH-1:0]     req1_wdata,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [ADDR_BITS-1:0] sram_a,
    output logic [WIDTH-1:0]     sram_d,
    input  logic [WIDTH-1:0]     sram_q,
    output logic [CNT_BITS-1:0]  grant0_cnt,
    output logic [CNT_BITS-1:0]  grant1_cnt
);
    logic       rr_last;
    logic [1:0] rsp_pend;
    logic       g0, g1, gnt, gwe;
    // Under contention the port that did not win last time goes first; nothing is granted in reset.
    always_comb begin
        g0         = ~RST & req0_valid & (~req1_valid | rr_last);
        g1         = ~RST & req1_valid & (~req0_valid | ~rr_last);
        gnt        = g0 | g1;
        gwe        = g0 ? req0_we : req1_we;
        req0_ready = g0;
        req1_ready = g1;
        sram_cen   = ~gnt;
        sram_wen   = gnt ? ~gwe : 1'b1;
        sram_a     = g0 ? req0_addr : g1 ? req1_addr : '0;
        sram_d     = g0 ? req0_wdata : g1 ? req1_wdata : '0;
        rsp_data   = sram_q;
        rsp0_valid = rsp_pend[0] & ~RST;
        rsp1_valid = rsp_pend[1] & ~RST;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_last    <= 1'b1;
            rsp_pend   <= 2'b00;
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (gnt) rr_last <= g1;
            rsp_pend <= (gnt && !gwe) ? {g1, g0} : 2'b00;
            if (g0 && !(&grant0_cnt)) grant0_cnt <= grant0_cnt + 1'b1;
            if (g1 && !(&grant1_cnt)) grant1_cnt <= grant1_cnt + 1'b1;
        end
    end
endmodule
